// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between a boot
// loader and a CPU.
//
// Modes:
//   BOOT - the loader owns the memory and the CPU is held.
//   RUN  - entered on ldr_done. The loader has fixed priority over the CPU,
//          but a waiting CPU is forced through after STARVE_MAX consecutive
//          loader grants.
//
// Ports:
//   clk, rst                        clock; asynchronous active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata  CPU request (byte address)
//   cpu_gnt/cpu_hold                CPU grant and stall, combinational
//   cpu_rdata/cpu_rvalid            CPU read return, one cycle after grant
//   ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_done
//                                   loader request (word address), done pulse
//   ldr_gnt/ldr_rdata/ldr_rvalid    loader grant and read return
//   m_read/m_write/m_addr/m_din/m_dout
//                                   memory port; m_dout is valid one cycle
//                                   after m_read
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_hold,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [13:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  input  logic        ldr_done,
  output logic        ldr_gnt,
  output logic [31:0] ldr_rdata,
  output logic        ldr_rvalid,
  output logic        m_read,
  output logic        m_write,
  output logic [13:0] m_addr,
  output logic [31:0] m_din,
  input  logic [31:0] m_dout
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } mode_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  mode_e       mode_q, mode_d;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  // Read tag: [1] = owner (1 = CPU, 0 = loader), [0] = valid
  logic [1:0]  rd_tag_q, rd_tag_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] ldr_rdata_q, ldr_rdata_d;
  logic        cpu_pending;
  logic        cpu_wins;
  logic        unused_cpu_addr;

  // Only the word index of the CPU byte address reaches the memory.
  assign unused_cpu_addr = ^{cpu_addr[31:16], cpu_addr[1:0]};

  // Arbitration, memory port mux, read return and next-state computation
  always_comb begin
    cpu_pending = cpu_rd | cpu_wr;
    cpu_wins    = 1'b0;
    cpu_gnt     = 1'b0;
    ldr_gnt     = 1'b0;
    cpu_hold    = 1'b1;
    mode_d      = mode_q;

    case (mode_q)
      BOOT: begin
        // Gate with rst so no grant leaks out while reset is held.
        ldr_gnt = ldr_req & rst;
        if (ldr_done) begin
          mode_d = RUN;
        end else begin
          mode_d = BOOT;
        end
      end
      RUN: begin
        cpu_wins = cpu_pending & (~ldr_req | (starve_cnt_q == STARVE_LIM));
        cpu_gnt  = cpu_wins;
        ldr_gnt  = ldr_req & ~cpu_wins;
        cpu_hold = cpu_pending & ~cpu_wins;
        mode_d   = RUN;
      end
      default: begin
        mode_d = BOOT;
      end
    endcase

    // Memory port follows the winner; rd+wr together is a write.
    if (cpu_gnt) begin
      m_read  = ~cpu_wr;
      m_write = cpu_wr;
      m_addr  = cpu_addr[15:2];
      m_din   = cpu_wdata;
    end else if (ldr_gnt) begin
      m_read  = ~ldr_we;
      m_write = ldr_we;
      m_addr  = ldr_addr;
      m_din   = ldr_wdata;
    end else begin
      m_read  = 1'b0;
      m_write = 1'b0;
      m_addr  = 14'd0;
      m_din   = 32'd0;
    end

    if (cpu_gnt && !cpu_wr) begin
      rd_tag_d = 2'b11;
    end else if (ldr_gnt && !ldr_we) begin
      rd_tag_d = 2'b01;
    end else begin
      rd_tag_d = 2'b00;
    end

    // Return data passes straight through from memory; otherwise hold.
    cpu_rvalid  = rd_tag_q[0] & rd_tag_q[1];
    ldr_rvalid  = rd_tag_q[0] & ~rd_tag_q[1];
    cpu_rdata   = cpu_rvalid ? m_dout : cpu_rdata_q;
    ldr_rdata   = ldr_rvalid ? m_dout : ldr_rdata_q;
    cpu_rdata_d = cpu_rdata;
    ldr_rdata_d = ldr_rdata;

    // Count loader wins while the CPU waits; saturates at the limit.
    if (mode_q != RUN) begin
      starve_cnt_d = 3'd0;
    end else if (!cpu_pending || cpu_gnt) begin
      starve_cnt_d = 3'd0;
    end else if (ldr_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State registers; reset drops any outstanding read tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= BOOT;
      starve_cnt_q <= 3'd0;
      rd_tag_q     <= 2'b00;
      cpu_rdata_q  <= 32'd0;
      ldr_rdata_q  <= 32'd0;
    end else begin
      mode_q       <= mode_d;
      starve_cnt_q <= starve_cnt_d;
      rd_tag_q     <= rd_tag_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand-written starvation and reset
// sequences, then randomized traffic checked against a transaction-level
// model of the arbiter and memory.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_hold;
  logic [31:0] cpu_rdata;
  logic        ldr_req, ldr_we, ldr_done;
  logic [13:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        m_read, m_write;
  logic [13:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_hold(cpu_hold),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_done(ldr_done), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears one cycle after m_read
  always @(posedge clk) begin
    if (m_write) mem[m_addr] <= m_din;
    if (m_read)  m_dout <= mem[m_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] ca, input logic [31:0] cw,
                       input logic lq, input logic lw, input logic [13:0] la, input logic [31:0] ld,
                       input logic dn);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cw;
    ldr_req = lq; ldr_we = lw; ldr_addr = la; ldr_wdata = ld; ldr_done = dn;
  endtask

  typedef struct {
    logic rd, wr; logic [31:0] caddr, cwdata;
    logic lreq, lwe; logic [13:0] laddr; logic [31:0] lwdata; logic ldone;
    logic cgnt, lgnt, hold, mrd, mwr; logic [13:0] maddr; logic [31:0] mdin;
    logic crv, lrv; logic [31:0] crd, lrd;
  } vec_t;

  vec_t vecs[11];

  // Model state for the randomized phase
  bit          run;
  int          waited;
  int          pend_owner;   // 0 none, 1 cpu, 2 loader
  logic [31:0] pend_data, last_c, last_l;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    m_dout = 32'd0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0);

    //          rd wr caddr          cwdata         lq lw laddr    lwdata         dn | cg lg hd mr mw maddr    mdin           crv lrv crd            lrd
    vecs[0]  = '{0, 0, 32'h0,         32'h0,         1, 1, 14'h010, 32'hDEADBEEF, 0,   0, 1, 1, 0, 1, 14'h010, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 0, 32'h00000040,  32'h0,         1, 0, 14'h010, 32'h0,        1,   0, 1, 1, 1, 0, 14'h010, 32'h0,        0, 0, 32'h0,        32'h0};
    vecs[2]  = '{1, 0, 32'h00000040,  32'h0,         0, 0, 14'h0,   32'h0,        0,   1, 0, 0, 1, 0, 14'h010, 32'h0,        0, 1, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{0, 0, 32'h0,         32'h0,         0, 0, 14'h0,   32'h0,        0,   0, 0, 0, 0, 0, 14'h0,   32'h0,        1, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4]  = '{1, 1, 32'h00000044,  32'h12345678,  0, 0, 14'h0,   32'h0,        0,   1, 0, 0, 0, 1, 14'h011, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[5]  = '{0, 0, 32'h0,         32'h0,         0, 0, 14'h0,   32'h0,        0,   0, 0, 0, 0, 0, 14'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[6]  = '{0, 0, 32'h0,         32'h0,         1, 0, 14'h011, 32'h0,        0,   0, 1, 0, 1, 0, 14'h011, 32'h0,        0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7]  = '{1, 0, 32'hFFFF0040,  32'h0,         0, 0, 14'h0,   32'h0,        0,   1, 0, 0, 1, 0, 14'h010, 32'h0,        0, 1, 32'hDEADBEEF, 32'h12345678};
    vecs[8]  = '{0, 0, 32'h0,         32'h0,         0, 0, 14'h0,   32'h0,        0,   0, 0, 0, 0, 0, 14'h0,   32'h0,        1, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[9]  = '{0, 1, 32'h00000048,  32'hA5A5A5A5,  1, 1, 14'h020, 32'h0BADF00D, 0,   0, 1, 1, 0, 1, 14'h020, 32'h0BADF00D, 0, 0, 32'hDEADBEEF, 32'h12345678};
    vecs[10] = '{0, 0, 32'h0,         32'h0,         0, 0, 14'h0,   32'h0,        0,   0, 0, 0, 0, 0, 14'h0,   32'h0,        0, 0, 32'hDEADBEEF, 32'h12345678};

    // Reset state
    repeat (2) @(posedge clk);
    ldr_req = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    chk("reset cpu_hold", cpu_hold, 1'b1);
    chk("reset ldr_gnt", ldr_gnt, 1'b0);
    chk("reset cpu_gnt", cpu_gnt, 1'b0);
    chk("reset m_read", m_read, 1'b0);
    chk("reset rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    chk("reset rdata", cpu_rdata | ldr_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].caddr, vecs[i].cwdata, vecs[i].lreq,
            vecs[i].lwe, vecs[i].laddr, vecs[i].lwdata, vecs[i].ldone);
      @(negedge clk);
      chk($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].cgnt);
      chk($sformatf("v%0d ldr_gnt", i), ldr_gnt, vecs[i].lgnt);
      chk($sformatf("v%0d cpu_hold", i), cpu_hold, vecs[i].hold);
      chk($sformatf("v%0d m_read", i), m_read, vecs[i].mrd);
      chk($sformatf("v%0d m_write", i), m_write, vecs[i].mwr);
      chk($sformatf("v%0d m_addr", i), m_addr, vecs[i].maddr);
      chk($sformatf("v%0d m_din", i), m_din, vecs[i].mdin);
      chk($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].crv);
      chk($sformatf("v%0d ldr_rvalid", i), ldr_rvalid, vecs[i].lrv);
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].crd);
      chk($sformatf("v%0d ldr_rdata", i), ldr_rdata, vecs[i].lrd);
      @(posedge clk); #1;
    end

    // Starvation: loader and CPU both held high -> L L L L C repeating
    drive(1'b1, 1'b0, 32'h00000040, 32'h0, 1'b1, 1'b1, 14'h030, 32'h11112222, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("starve%0d cpu_gnt", k), cpu_gnt, (k % 5) == 4);
      chk($sformatf("starve%0d ldr_gnt", k), ldr_gnt, (k % 5) != 4);
      chk($sformatf("starve%0d cpu_hold", k), cpu_hold, (k % 5) != 4);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // Reset in the cycle after a read grant
    drive(1'b1, 1'b0, 32'h00000040, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstmid grant", cpu_gnt, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    ldr_req = 1'b1;
    @(negedge clk);
    chk("rstmid rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    chk("rstmid cpu_rdata", cpu_rdata, 32'd0);
    chk("rstmid grants", {cpu_gnt, ldr_gnt, m_read, m_write}, 4'b0000);
    chk("rstmid hold", cpu_hold, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    ldr_req = 1'b0;
    @(negedge clk);
    chk("after rst rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    chk("after rst boot cpu_gnt", cpu_gnt, 1'b0);
    chk("after rst boot hold", cpu_hold, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h00000040, 32'h0, 1'b1, 1'b0, 14'h005, 32'h0, 1'b0);
    @(negedge clk);
    chk("after rst boot ldr_gnt", ldr_gnt, 1'b1);
    chk("after rst boot rvalid", {cpu_rvalid, ldr_rvalid}, 2'b00);
    @(posedge clk); #1;

    // Randomized traffic against a transaction-level model
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 16384; i++) ref_mem[i] = mem[i];
    run = 1'b0; waited = 0; pend_owner = 0; pend_data = 32'd0;
    last_c = 32'd0; last_l = 32'd0;

    for (int c = 0; c < 3000; c++) begin
      logic e_cg, e_lg, e_hold, e_rd, e_wr, pending;
      logic [13:0] e_addr;
      logic [31:0] e_din, e_crd, e_lrd;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            {16'($urandom), 11'd0, 3'($urandom), 2'($urandom)}, $urandom,
            1'($urandom_range(0, 9) < 6), 1'($urandom), {11'd0, 3'($urandom)}, $urandom,
            1'($urandom_range(0, 39) == 0));
      pending = cpu_rd | cpu_wr;
      if (!run) begin
        e_cg = 1'b0;
        e_lg = ldr_req;
        e_hold = 1'b1;
      end else begin
        e_cg = pending && (!ldr_req || waited >= STARVE_MAX);
        e_lg = ldr_req && !e_cg;
        e_hold = pending && !e_cg;
      end
      e_rd = 1'b0; e_wr = 1'b0; e_addr = 14'd0; e_din = 32'd0;
      if (e_cg) begin
        e_wr = cpu_wr; e_rd = !cpu_wr; e_addr = cpu_addr[15:2]; e_din = cpu_wdata;
      end else if (e_lg) begin
        e_wr = ldr_we; e_rd = !ldr_we; e_addr = ldr_addr; e_din = ldr_wdata;
      end
      e_crd = (pend_owner == 1) ? pend_data : last_c;
      e_lrd = (pend_owner == 2) ? pend_data : last_l;

      @(negedge clk);
      chk("rnd cpu_gnt", cpu_gnt, e_cg);
      chk("rnd ldr_gnt", ldr_gnt, e_lg);
      chk("rnd cpu_hold", cpu_hold, e_hold);
      chk("rnd m_rw", {m_read, m_write}, {e_rd, e_wr});
      chk("rnd m_addr", m_addr, e_addr);
      chk("rnd m_din", m_din, e_din);
      chk("rnd cpu_rvalid", cpu_rvalid, pend_owner == 1);
      chk("rnd ldr_rvalid", ldr_rvalid, pend_owner == 2);
      chk("rnd cpu_rdata", cpu_rdata, e_crd);
      chk("rnd ldr_rdata", ldr_rdata, e_lrd);

      last_c = e_crd;
      last_l = e_lrd;
      pend_owner = 0;
      if (e_rd) begin
        pend_owner = e_cg ? 1 : 2;
        pend_data = ref_mem[e_addr];
      end
      if (e_wr) ref_mem[e_addr] = e_din;
      if (!run || !pending || e_cg) waited = 0;
      else if (e_lg && waited < STARVE_MAX) waited = waited + 1;
      if (!run && ldr_done) run = 1'b1;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive loader grants while a CPU request is pending.
REQ-002 SHALL have ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- cpu_rd  input  1  CPU read request.
- cpu_wr  input  1  CPU write request.
- cpu_addr  input  32  CPU byte address.
- cpu_wdata  input  32  CPU write data.
- cpu_gnt  output  1  CPU access issued this cycle.
- cpu_rdata  output  32  CPU read data.
- cpu_rvalid  output  1  cpu_rdata valid.
- cpu_hold  output  1  CPU must not advance PC or commit.
- ldr_req  input  1  loader access request.
- ldr_we  input  1  loader write (1) / read (0).
- ldr_addr  input  14  loader word address.
- ldr_wdata  input  32  loader write data.
- ldr_done  input  1  loader finished image, one-cycle pulse.
- ldr_gnt  output  1  loader access issued this cycle.
- ldr_rdata  output  32  loader read data.
- ldr_rvalid  output  1  ldr_rdata valid.
- m_read  output  1  memory read strobe.
- m_write  output  1  memory write strobe.
- m_addr  output  14  memory word address.
- m_din  output  32  memory write data.
- m_dout  input  32  memory read data, valid one cycle after m_read.

Function
REQ-003 SHALL implement a mode FSM with states BOOT and RUN; reset enters BOOT.
REQ-004 In BOOT, SHALL assert cpu_hold, never assert cpu_gnt, and grant ldr_req every cycle it is high.
REQ-005 BOOT->RUN SHALL occur on the edge where ldr_done=1; RUN has no exit except reset.
REQ-006 A ldr_done coinciding with ldr_req in BOOT SHALL still grant that access; the mode changes on the same edge.
REQ-007 In RUN, cpu_pending = cpu_rd|cpu_wr; cpu_rd and cpu_wr both high SHALL be treated as a write only.
REQ-008 In RUN, SHALL use fixed priority loader over CPU, except that the CPU wins when starve_cnt == STARVE_MAX.
REQ-009 starve_cnt (3 bits): increments on a loader grant with cpu_pending; clears on a cpu_gnt or any cycle with cpu_pending=0; saturates at STARVE_MAX.
REQ-010 In RUN, cpu_hold SHALL equal cpu_pending & ~cpu_gnt (combinational).
REQ-011 Grants SHALL be combinational in the request cycle; at most one of cpu_gnt/ldr_gnt is high per cycle.
REQ-012 On a grant, SHALL drive m_read/m_write, m_addr (cpu_addr[15:2] or ldr_addr) and m_din from the winner; with no grant, m_read=m_write=0 and m_addr=m_din=0.
REQ-013 SHALL register a 2-bit read tag {owner, valid} on each read grant; on the next cycle the tagged port gets *_rvalid=1 and *_rdata=m_dout.
REQ-014 Read latency SHALL be exactly one cycle after grant; back-to-back reads, including reads alternating between owners, SHALL each return in order with no bubble.
REQ-015 cpu_rdata/ldr_rdata SHALL hold their last returned value when rvalid=0.
REQ-016 Writes SHALL produce no rvalid.

Reset
REQ-017 While rst=0: state=BOOT, starve_cnt=0, read tag cleared, cpu_hold=1, cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0; gnt and m_* outputs are 0.
REQ-018 Reset asserted mid-read SHALL discard the pending rvalid; no data is returned after release.

Verification
REQ-019 Boot load: in BOOT, loader writes 0xDEADBEEF to addr 0x0010, then pulses ldr_done -> m_write=1, m_addr=0x0010, cpu_hold=1 until the edge after ldr_done, then 0 with no CPU request.
REQ-020 CPU read in RUN: cpu_rd, cpu_addr=0x00000040 -> cpu_gnt=1, m_addr=0x0010 in the same cycle; cpu_rvalid=1, cpu_rdata=0xDEADBEEF the next cycle.
REQ-021 Starvation: ldr_req and cpu_rd held high continuously -> 4 ldr_gnt, 1 cpu_gnt, repeating; cpu_hold=1 during the 4 loader cycles.
REQ-022 Simultaneous rd+wr: cpu_rd=cpu_wr=1 -> m_write=1, m_read=0, no cpu_rvalid.
REQ-023 Interleaved reads: loader read at cycle n, CPU read at n+1 -> ldr_rvalid at n+1, cpu_rvalid at n+2, correct data on each port.
REQ-024 Reset mid-read: rst low in the cycle after a read grant -> cpu_rvalid=ldr_rvalid=0; after release, FSM in BOOT.
